adpll_ctrl: RTL and testbench
=============================

Name: adpll_ctrl

Overview:
- Configuration/lock-management controller that drives the ADPLL's multiplier select and reset inputs, and consumes the ADPLL's LOCK output.
- Accepts a multiplier request over a valid/ready handshake, applies it, and holds the ADPLL in reset for a fixed interval.
- Qualifies LOCK, retries on timeout, and reports locked, fault and loss-of-lock status.
- Sits between system control logic and the ADPLL, clocked by the same reference clock.

Parameters:
- RST_CYCLES, 4: REF_CLK cycles PLL_RESET is held on each (re)start (>=1).
- LOCK_TIMEOUT, 64: cycles allowed from end of reset hold to qualified lock.
- STABLE_CYCLES, 8: consecutive cycles synchronized LOCK must be high to qualify.
- MAX_RETRY, 2: restart attempts after the first before entering FAULT.
- DEFAULT_MULT, 3'd1: multiplier applied after controller reset.

Ports:
- REF_CLK  in  1  reference clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low controller reset.
- CFG_VALID  in  1  multiplier request valid.
- CFG_MULT  in  3  requested multiplier code.
- CFG_READY  out  1  controller can accept a request.
- CFG_ERR  out  1  one-cycle pulse: illegal code (0) was accepted and ignored.
- LOCK  in  1  ADPLL lock, asynchronous to controller; 2-flop synchronized internally.
- M2  out  1  multiplier bit 2 to ADPLL.
- M1  out  1  multiplier bit 1 to ADPLL.
- M0  out  1  multiplier bit 0 to ADPLL.
- PLL_RESET  out  1  active-high ADPLL reset.
- LOCKED_OK  out  1  qualified lock.
- FAULT  out  1  retries exhausted.
- LOSS_CNT  out  8  saturating count of loss-of-lock events.

Behaviour:
- Outputs: all registered.
- Reset values while RESET=0:
  - state=RST_HOLD, {M2,M1,M0}=DEFAULT_MULT, PLL_RESET=1.
  - CFG_READY=0, CFG_ERR=0, LOCKED_OK=0, FAULT=0, LOSS_CNT=0.
  - Retry count=0; sync flops=0.
- States: RST_HOLD, WAIT_LOCK, QUALIFY, LOCKED, FAULT.
- RST_HOLD:
  - PLL_RESET=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with PLL_RESET=0.
  - Timeout counter cleared on this exit.
- WAIT_LOCK:
  - lock_s=1 -> QUALIFY, stability counter cleared.
  - Timeout counter reaching LOCK_TIMEOUT -> retry decision.
- QUALIFY:
  - lock_s stays 1 for STABLE_CYCLES consecutive cycles -> LOCKED; LOCKED_OK=1 on that edge.
  - lock_s=0 -> WAIT_LOCK.
  - The timeout counter keeps running through WAIT_LOCK and QUALIFY; it is not restarted by a LOCK glitch. Timeout in QUALIFY is handled as in WAIT_LOCK.
- Retry decision:
  - retry<MAX_RETRY -> retry+1, RST_HOLD.
  - Otherwise -> FAULT with FAULT=1 and PLL_RESET=1 held.
- LOCKED:
  - lock_s=0 -> LOSS_CNT+1 (saturates at 255), LOCKED_OK=0, retry=0, RST_HOLD.
- Handshake:
  - CFG_READY=1 only in LOCKED and FAULT. Transfer on CFG_VALID&CFG_READY.
  - Legal code (1..7): M bits<=code, retry=0, FAULT=0, LOCKED_OK=0, RST_HOLD, PLL_RESET=1, all on the accepting edge.
  - Code 0: CFG_ERR pulses one cycle; state and outputs otherwise unchanged.
  - CFG_VALID while not ready: ignored; requester holds.
- Simultaneous legal transfer and loss of lock in LOCKED: the config wins and LOSS_CNT is not incremented.
- M bits change only on reset or accepted legal config, so they are always stable while PLL_RESET=1 at restart.
- LOCK response latency: a LOCK edge is visible to the FSM 2 cycles later.
- Async RESET mid-operation: immediate return to reset values; no config is retained.

Decomposition:
- Shared package adpll_pkg:
  - State enum.
  - Multiplier code width (3).
  - Illegal code constant MULT_ILLEGAL=3'd0.
  - LOSS_CNT width.
- Sub-module sync2: 2-flop synchronizer, async active-low reset, used for LOCK.
- FSM and counters live in adpll_ctrl.

Test Plan:
- Power-up, LOCK rises at cycle 10 and stays high -> PLL_RESET high 4 cycles; LOCKED_OK=1 exactly 2+8 cycles after LOCK rise; M=3'b001; CFG_READY=1.
- LOCK never asserted -> 3 reset pulses of 4 cycles, each followed by 64 waiting cycles, then FAULT=1, PLL_RESET=1, LOCKED_OK=0.
- LOCK glitches low once during QUALIFY -> return to WAIT_LOCK; lock declared only after 8 further stable cycles; no extra reset pulse if within the 64-cycle budget.
- In LOCKED, CFG_MULT=5 with VALID -> next edge M=3'b101, PLL_RESET=1 for 4 cycles, CFG_READY=0 until relock; CFG_MULT=0 instead -> CFG_ERR one-cycle pulse, M unchanged, still LOCKED.
- In LOCKED, LOCK drops -> LOSS_CNT 0->1 and relock sequence; 300 repeated drops -> LOSS_CNT saturates at 255; legal config in the same cycle as a drop -> LOSS_CNT unchanged.
- RESET low during QUALIFY, then released -> all outputs return to reset values; M=DEFAULT_MULT; sequence restarts from RST_HOLD.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL configuration / lock-management controller.
//
// Contents:
//   MULT_W        width of the ADPLL multiplier code
//   MULT_ILLEGAL  multiplier code that is rejected on the config interface
//   LOSS_W        width of the loss-of-lock event counter
//   state_t       controller FSM states
//   sat_inc_loss  saturating increment for the loss-of-lock counter
package adpll_pkg;

    localparam int MULT_W = 3;
    localparam logic [MULT_W-1:0] MULT_ILLEGAL = 3'd0;
    localparam int LOSS_W = 8;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_QUALIFY   = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
        return (&v) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
//
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (both flops clear to 0)
//   d      in   asynchronous input
//   q      out  synchronized output, two clk edges behind d
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/adpll_ctrl.sv
// ADPLL configuration and lock-management controller.
//
// Accepts a multiplier code over a valid/ready handshake, drives it onto the
// ADPLL M2..M0 pins, pulses the ADPLL reset for RST_CYCLES cycles, then waits
// for a stable LOCK. A restart is attempted on lock timeout; once MAX_RETRY
// restarts have failed the controller parks in FAULT with the PLL held in reset.
// Loss of lock after qualification is counted and triggers a fresh restart.
//
// Ports:
//   REF_CLK    in   reference clock, all logic on its rising edge
//   RESET      in   asynchronous active-low controller reset
//   CFG_VALID  in   multiplier request valid
//   CFG_MULT   in   requested multiplier code (0 is illegal)
//   CFG_READY  out  request can be accepted (LOCKED or FAULT)
//   CFG_ERR    out  one-cycle pulse when an illegal code was accepted
//   LOCK       in   ADPLL lock, asynchronous, synchronized internally
//   M2/M1/M0   out  multiplier bits to the ADPLL
//   PLL_RESET  out  active-high ADPLL reset
//   LOCKED_OK  out  qualified lock
//   FAULT      out  retries exhausted
//   LOSS_CNT   out  saturating count of loss-of-lock events
module adpll_ctrl
    import adpll_pkg::*;
#(
    parameter int                RST_CYCLES    = 4,
    parameter int                LOCK_TIMEOUT  = 64,
    parameter int                STABLE_CYCLES = 8,
    parameter int                MAX_RETRY     = 2,
    parameter logic [MULT_W-1:0] DEFAULT_MULT  = 3'd1
) (
    input  logic              REF_CLK,
    input  logic              RESET,
    input  logic              CFG_VALID,
    input  logic [MULT_W-1:0] CFG_MULT,
    output logic              CFG_READY,
    output logic              CFG_ERR,
    input  logic              LOCK,
    output logic              M2,
    output logic              M1,
    output logic              M0,
    output logic              PLL_RESET,
    output logic              LOCKED_OK,
    output logic              FAULT,
    output logic [LOSS_W-1:0] LOSS_CNT
);

    // +2 keeps every counter at least one bit wide for the smallest parameters.
    localparam int RST_W   = $clog2(RST_CYCLES + 2);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 2);
    localparam int STAB_W  = $clog2(STABLE_CYCLES + 2);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    // The WAIT_LOCK cycle that sees lock_s high already counts as the first
    // stable cycle, so QUALIFY needs STABLE_CYCLES-1 more of them.
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

    logic lock_s;

    state_t              state_q,     state_d;
    logic [RST_W-1:0]    rst_cnt_q,   rst_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic [STAB_W-1:0]   stab_cnt_q,  stab_cnt_d;
    logic [RETRY_W-1:0]  retry_q,     retry_d;
    logic [MULT_W-1:0]   mult_q,      mult_d;
    logic                pll_reset_q, pll_reset_d;
    logic                locked_ok_q, locked_ok_d;
    logic                fault_q,     fault_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_err_q,   cfg_err_d;
    logic [LOSS_W-1:0]   loss_cnt_q,  loss_cnt_d;

    logic timeout;
    logic cfg_take;
    logic cfg_legal;
    logic do_timeout;
    logic do_config;

    sync2 u_lock_sync (
        .clk   (REF_CLK),
        .rst_n (RESET),
        .d     (LOCK),
        .q     (lock_s)
    );

    assign timeout   = (to_cnt_q == TO_LAST);
    assign cfg_take  = CFG_VALID & cfg_ready_q;
    assign cfg_legal = (CFG_MULT != MULT_ILLEGAL);

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;
        stab_cnt_d  = stab_cnt_q;
        retry_d     = retry_q;
        mult_d      = mult_q;
        pll_reset_d = pll_reset_q;
        locked_ok_d = locked_ok_q;
        fault_d     = fault_q;
        cfg_err_d   = 1'b0;
        loss_cnt_d  = loss_cnt_q;
        do_timeout  = 1'b0;
        do_config   = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                pll_reset_d = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d     = ST_WAIT_LOCK;
                    rst_cnt_d   = '0;
                    to_cnt_d    = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (timeout) begin
                    do_timeout = 1'b1;
                end else if (lock_s) begin
                    if (STABLE_CYCLES <= 1) begin
                        state_d     = ST_LOCKED;
                        locked_ok_d = 1'b1;
                    end else begin
                        state_d    = ST_QUALIFY;
                        stab_cnt_d = '0;
                    end
                end
            end

            ST_QUALIFY: begin
                // Timeout keeps running here; a glitch only sends us back
                // to WAIT_LOCK, it does not buy a fresh budget.
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (lock_s && (stab_cnt_q == STAB_LAST)) begin
                    state_d     = ST_LOCKED;
                    locked_ok_d = 1'b1;
                end else if (timeout) begin
                    do_timeout = 1'b1;
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end

            ST_LOCKED: begin
                // A legal config overrides a simultaneous loss of lock.
                if (cfg_take && cfg_legal) begin
                    do_config = 1'b1;
                end else begin
                    if (cfg_take) begin
                        cfg_err_d = 1'b1;
                    end
                    if (!lock_s) begin
                        loss_cnt_d  = sat_inc_loss(loss_cnt_q);
                        locked_ok_d = 1'b0;
                        retry_d     = '0;
                        state_d     = ST_RST_HOLD;
                        rst_cnt_d   = '0;
                        pll_reset_d = 1'b1;
                    end
                end
            end

            ST_FAULT: begin
                pll_reset_d = 1'b1;
                if (cfg_take) begin
                    if (cfg_legal) begin
                        do_config = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_RST_HOLD;
                rst_cnt_d   = '0;
                pll_reset_d = 1'b1;
            end
        endcase

        if (do_timeout) begin
            pll_reset_d = 1'b1;
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_d   = retry_q + RETRY_W'(1);
                state_d   = ST_RST_HOLD;
                rst_cnt_d = '0;
            end else begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        end

        if (do_config) begin
            mult_d      = CFG_MULT;
            retry_d     = '0;
            fault_d     = 1'b0;
            locked_ok_d = 1'b0;
            state_d     = ST_RST_HOLD;
            rst_cnt_d   = '0;
            pll_reset_d = 1'b1;
        end

        cfg_ready_d = (state_d == ST_LOCKED) || (state_d == ST_FAULT);
    end

    always_ff @(posedge REF_CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_RST_HOLD;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stab_cnt_q  <= '0;
            retry_q     <= '0;
            mult_q      <= DEFAULT_MULT;
            pll_reset_q <= 1'b1;
            locked_ok_q <= 1'b0;
            fault_q     <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            retry_q     <= retry_d;
            mult_q      <= mult_d;
            pll_reset_q <= pll_reset_d;
            locked_ok_q <= locked_ok_d;
            fault_q     <= fault_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign M2        = mult_q[2];
    assign M1        = mult_q[1];
    assign M0        = mult_q[0];
    assign PLL_RESET = pll_reset_q;
    assign LOCKED_OK = locked_ok_q;
    assign FAULT     = fault_q;
    assign CFG_READY = cfg_ready_q;
    assign CFG_ERR   = cfg_err_q;
    assign LOSS_CNT  = loss_cnt_q;

endmodule

// File: tb/tb_adpll_ctrl.sv
// Directed bench for adpll_ctrl with default parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=8, MAX_RETRY=2, DEFAULT_MULT=1).
// Edge numbers n below count rising edges after the event of interest;
// inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_adpll_ctrl;

    logic       REF_CLK = 1'b0;
    logic       RESET;
    logic       CFG_VALID;
    logic [2:0] CFG_MULT;
    logic       CFG_READY;
    logic       CFG_ERR;
    logic       LOCK;
    logic       M2, M1, M0;
    logic       PLL_RESET;
    logic       LOCKED_OK;
    logic       FAULT;
    logic [7:0] LOSS_CNT;

    int checks_cnt = 0;
    int errors_cnt = 0;

    adpll_ctrl dut (
        .REF_CLK   (REF_CLK),
        .RESET     (RESET),
        .CFG_VALID (CFG_VALID),
        .CFG_MULT  (CFG_MULT),
        .CFG_READY (CFG_READY),
        .CFG_ERR   (CFG_ERR),
        .LOCK      (LOCK),
        .M2        (M2),
        .M1        (M1),
        .M0        (M0),
        .PLL_RESET (PLL_RESET),
        .LOCKED_OK (LOCKED_OK),
        .FAULT     (FAULT),
        .LOSS_CNT  (LOSS_CNT)
    );

    always #5 REF_CLK = ~REF_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge REF_CLK);
        #1;
    endtask

    task automatic wait_locked(input string tag);
        int n = 0;
        while (!LOCKED_OK && n < 100) begin
            tick();
            n++;
        end
        check(tag, LOCKED_OK, 1);
    endtask

    task automatic send_cfg(input logic [2:0] code);
        CFG_VALID = 1'b1;
        CFG_MULT  = code;
        tick();
        CFG_VALID = 1'b0;
        $display("txn cfg mult=%0d at %0t", code, $time);
    endtask

    function automatic logic [2:0] mbits();
        return {M2, M1, M0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b0;
        LOCK      = 1'b0;
        CFG_VALID = 1'b0;
        CFG_MULT  = 3'd0;

        // ---- Reset values and power-up lock ----
        tick(); tick(); tick();
        check("rst_pll", PLL_RESET, 1);
        check("rst_m", mbits(), 3'b001);
        check("rst_ready", CFG_READY, 0);
        check("rst_lockok", LOCKED_OK, 0);
        check("rst_fault", FAULT, 0);
        check("rst_loss", LOSS_CNT, 0);
        check("rst_err", CFG_ERR, 0);
        RESET = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 10) LOCK = 1'b1;
            case (n)
                1:  check("pu_pll_e1", PLL_RESET, 1);
                3:  check("pu_pll_e3", PLL_RESET, 1);
                4:  check("pu_pll_e4", PLL_RESET, 0);
                19: check("pu_lock_e19", LOCKED_OK, 0);
                20: begin
                    check("pu_lock_e20", LOCKED_OK, 1);
                    check("pu_m", mbits(), 3'b001);
                    check("pu_ready", CFG_READY, 1);
                end
                default: ;
            endcase
        end
        $display("txn power-up lock done at %0t", $time);

        // ---- Never locks: three restarts then FAULT; VALID ignored while not ready ----
        RESET     = 1'b0;
        LOCK      = 1'b0;
        CFG_VALID = 1'b1;
        CFG_MULT  = 3'd7;
        tick(); tick();
        RESET = 1'b1;
        for (int n = 1; n <= 204; n++) begin
            tick();
            if (n == 203) CFG_VALID = 1'b0;
            case (n)
                3:   check("nl_p1_hi", PLL_RESET, 1);
                4:   check("nl_p1_lo", PLL_RESET, 0);
                67:  check("nl_w1_lo", PLL_RESET, 0);
                68:  check("nl_p2_rise", PLL_RESET, 1);
                71:  check("nl_p2_hi", PLL_RESET, 1);
                72:  check("nl_p2_lo", PLL_RESET, 0);
                135: check("nl_w2_lo", PLL_RESET, 0);
                136: check("nl_p3_rise", PLL_RESET, 1);
                139: check("nl_p3_hi", PLL_RESET, 1);
                140: check("nl_p3_lo", PLL_RESET, 0);
                203: begin
                    check("nl_pre_fault", FAULT, 0);
                    check("nl_pre_pll", PLL_RESET, 0);
                    check("nl_m_held", mbits(), 3'b001);
                end
                204: begin
                    check("nl_fault", FAULT, 1);
                    check("nl_fault_pll", PLL_RESET, 1);
                    check("nl_fault_lockok", LOCKED_OK, 0);
                    check("nl_fault_ready", CFG_READY, 1);
                end
                default: ;
            endcase
        end
        $display("txn no-lock fault reached at %0t", $time);

        // ---- Recover from FAULT with code 3, glitch LOCK during QUALIFY ----
        send_cfg(3'd3);
        LOCK = 1'b1;
        check("fr_m", mbits(), 3'b011);
        check("fr_fault", FAULT, 0);
        check("fr_pll", PLL_RESET, 1);
        check("fr_ready", CFG_READY, 0);
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 7) LOCK = 1'b0;
            if (n == 8) LOCK = 1'b1;
            case (n)
                4:  check("gl_pll_lo", PLL_RESET, 0);
                12: check("gl_nolock_e12", LOCKED_OK, 0);
                17: check("gl_nolock_e17", LOCKED_OK, 0);
                18: begin
                    check("gl_lock_e18", LOCKED_OK, 1);
                    check("gl_no_restart", PLL_RESET, 0);
                end
                default: ;
            endcase
        end

        // ---- Legal reconfig from LOCKED ----
        send_cfg(3'd5);
        check("c5_m", mbits(), 3'b101);
        check("c5_pll", PLL_RESET, 1);
        check("c5_ready", CFG_READY, 0);
        check("c5_lockok", LOCKED_OK, 0);
        for (int n = 1; n <= 12; n++) begin
            tick();
            case (n)
                3:  check("c5_pll_e3", PLL_RESET, 1);
                4:  check("c5_pll_e4", PLL_RESET, 0);
                11: check("c5_ready_e11", CFG_READY, 0);
                12: begin
                    check("c5_ready_e12", CFG_READY, 1);
                    check("c5_lock_e12", LOCKED_OK, 1);
                end
                default: ;
            endcase
        end

        // ---- Illegal code in LOCKED ----
        send_cfg(3'd0);
        check("c0_err", CFG_ERR, 1);
        check("c0_m", mbits(), 3'b101);
        check("c0_lockok", LOCKED_OK, 1);
        check("c0_pll", PLL_RESET, 0);
        tick();
        check("c0_err_clr", CFG_ERR, 0);
        check("c0_still_locked", LOCKED_OK, 1);

        // ---- Single loss of lock ----
        LOCK = 1'b0;
        tick();
        LOCK = 1'b1;
        tick(); tick();
        check("ll_cnt", LOSS_CNT, 1);
        check("ll_lockok", LOCKED_OK, 0);
        check("ll_pll", PLL_RESET, 1);
        $display("txn loss-of-lock 1 at %0t", $time);
        wait_locked("ll_relock");

        // ---- Loss of lock in the same cycle as a legal config ----
        LOCK = 1'b0;
        tick(); tick();
        send_cfg(3'd6);
        LOCK = 1'b1;
        check("sim_m", mbits(), 3'b110);
        check("sim_loss", LOSS_CNT, 1);
        check("sim_pll", PLL_RESET, 1);
        check("sim_lockok", LOCKED_OK, 0);
        wait_locked("sim_relock");

        // ---- Saturation of loss counter ----
        for (int i = 0; i < 299; i++) begin
            LOCK = 1'b0;
            tick();
            LOCK = 1'b1;
            tick(); tick();
            wait_locked("sat_relock");
        end
        $display("txn 299 extra loss events at %0t", $time);
        check("sat_loss", LOSS_CNT, 255);

        // ---- Async reset during QUALIFY ----
        send_cfg(3'd7);
        for (int n = 1; n <= 6; n++) tick();
        check("mr_qualify_lockok", LOCKED_OK, 0);
        check("mr_m7", mbits(), 3'b111);
        RESET = 1'b0;
        #2;
        check("mr_m", mbits(), 3'b001);
        check("mr_pll", PLL_RESET, 1);
        check("mr_loss", LOSS_CNT, 0);
        check("mr_ready", CFG_READY, 0);
        check("mr_lockok", LOCKED_OK, 0);
        check("mr_fault", FAULT, 0);
        check("mr_err", CFG_ERR, 0);
        tick(); tick();
        RESET = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            case (n)
                3:  check("mr_pll_e3", PLL_RESET, 1);
                4:  check("mr_pll_e4", PLL_RESET, 0);
                11: check("mr_lock_e11", LOCKED_OK, 0);
                12: begin
                    check("mr_lock_e12", LOCKED_OK, 1);
                    check("mr_m_e12", mbits(), 3'b001);
                end
                default: ;
            endcase
        end
        $display("txn reset-restart lock at %0t", $time);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
